// File: rtl/rtc_bcd_clock.sv
// ---------------------------------------------------------------------------
// rtc_bcd_clock
//
// Real-time clock producing a 24-bit BCD time word HH:MM:SS. A prescaler
// divides clk down to 1 Hz. Seconds, minutes and hours count in BCD with
// carry. A validated time load may be requested at any time, including while
// the clock is frozen. One-cycle second and minute strobes are issued for
// scheduling logic. All outputs are registered.
//
// Optional feature macro: ALARM_MATCH_EN
//   When defined, adds an HH:MM alarm compare that pulses alarm_hit together
//   with min_tick when the new time matches alarm_time. It also pulses when
//   a load lands exactly on the alarm minute at second 00.
//
// Parameters
//   CLK_FREQ      clk cycles per second (>= 2)
//   HOUR_MAX_BCD  last valid hour before wrap to 00 (BCD)
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   hold        in   1 = freeze prescaler and time counters
//   set_en      in   one-cycle load request
//   set_time    in   [23:16] HH, [15:8] MM, [7:0] SS, BCD
//   set_ack     out  one-cycle pulse, load accepted
//   set_err     out  one-cycle pulse, load rejected
//   time_dout   out  current time, BCD, same layout as set_time
//   sec_tick    out  one-cycle pulse on each seconds increment
//   min_tick    out  one-cycle pulse when seconds wrap 59->00
//   alarm_time  in   (ALARM_MATCH_EN) HH:MM BCD alarm value
//   alarm_hit   out  (ALARM_MATCH_EN) one-cycle alarm match pulse
// ---------------------------------------------------------------------------
module rtc_bcd_clock #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter logic [7:0]  HOUR_MAX_BCD = 8'h23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        set_en,
  input  logic [23:0] set_time,
  output logic        set_ack,
  output logic        set_err,
  output logic [23:0] time_dout,
  output logic        sec_tick,
  output logic        min_tick
`ifdef ALARM_MATCH_EN
  ,
  input  logic [15:0] alarm_time,
  output logic        alarm_hit
`endif
);

  localparam int unsigned   PW       = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ - 1);

  // Field check: tens nibble bounded by tens_max, ones nibble a BCD digit.
  function automatic logic bcd_field_ok(input logic [7:0] f,
                                        input logic [3:0] tens_max);
    return (f[7:4] <= tens_max) && (f[3:0] <= 4'd9);
  endfunction

  // Advance a 00..59 BCD field by one; wraps 59 -> 00.
  function automatic logic [7:0] sexa_inc(input logic [7:0] f);
    logic [7:0] r;
    if (f[3:0] == 4'd9) begin
      if (f[7:4] == 4'd5) r = 8'h00;
      else                r = {f[7:4] + 4'd1, 4'd0};
    end else begin
      r = {f[7:4], f[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Advance the hours field by one; wraps HOUR_MAX_BCD -> 00.
  function automatic logic [7:0] hour_inc(input logic [7:0] f);
    logic [7:0] r;
    if (f == HOUR_MAX_BCD)    r = 8'h00;
    else if (f[3:0] == 4'd9)  r = {f[7:4] + 4'd1, 4'd0};
    else                      r = {f[7:4], f[3:0] + 4'd1};
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   time_q, time_d;
  logic          sec_tick_q, sec_tick_d;
  logic          min_tick_q, min_tick_d;
  logic          set_ack_q, set_ack_d;
  logic          set_err_q, set_err_d;

  logic          terminal;
  logic          set_valid;
  logic          load_ok;
  logic          ss_wrap;
  logic          mm_wrap;
  logic [23:0]   time_inc;

  assign terminal  = (presc_q == PRESC_TC) && !hold;

  assign set_valid = bcd_field_ok(set_time[7:0],   4'd5) &&
                     bcd_field_ok(set_time[15:8],  4'd5) &&
                     bcd_field_ok(set_time[23:16], 4'd9) &&
                     (set_time[23:16] <= HOUR_MAX_BCD);

  assign load_ok   = set_en && set_valid;

  assign ss_wrap   = (time_q[7:0]  == 8'h59);
  assign mm_wrap   = (time_q[15:8] == 8'h59);

  always_comb begin
    time_inc         = time_q;
    time_inc[7:0]    = sexa_inc(time_q[7:0]);
    if (ss_wrap) begin
      time_inc[15:8] = sexa_inc(time_q[15:8]);
      if (mm_wrap) begin
        time_inc[23:16] = hour_inc(time_q[23:16]);
      end
    end
  end

  always_comb begin
    presc_d    = presc_q;
    time_d     = time_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    set_ack_d  = 1'b0;
    set_err_d  = set_en && !set_valid;

    if (load_ok) begin
      // A valid load overrides a coincident terminal count: no increment.
      presc_d   = '0;
      time_d    = set_time;
      set_ack_d = 1'b1;
    end else if (terminal) begin
      presc_d    = '0;
      time_d     = time_inc;
      sec_tick_d = 1'b1;
      min_tick_d = ss_wrap;
    end else if (!hold) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      time_q     <= 24'h000000;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      set_ack_q  <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      time_q     <= time_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
      set_ack_q  <= set_ack_d;
      set_err_q  <= set_err_d;
    end
  end

  assign time_dout = time_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;
  assign set_ack   = set_ack_q;
  assign set_err   = set_err_q;

`ifdef ALARM_MATCH_EN
  logic alarm_hit_q, alarm_hit_d;

  // Either a minute rollover onto the alarm, or a load landing on HH:MM:00.
  always_comb begin
    alarm_hit_d = 1'b0;
    if (load_ok) begin
      alarm_hit_d = (set_time[7:0] == 8'h00) && (set_time[23:8] == alarm_time);
    end else if (terminal && ss_wrap) begin
      alarm_hit_d = (time_inc[23:8] == alarm_time);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_hit_q <= 1'b0;
    else        alarm_hit_q <= alarm_hit_d;
  end

  assign alarm_hit = alarm_hit_q;
`endif

endmodule

// File: doc/rtc_bcd_clock.md
Name: rtc_bcd_clock

Overview:
Real-time clock that generates the 24-bit BCD time word (HH:MM:SS) consumed by the pill-box controller and the LCD1602 display stage. It divides the system clock down to 1 Hz and counts seconds, minutes and hours with carry. It accepts a validated time-load request from the keypad/controller path and emits one-cycle second and minute tick strobes for scheduling logic.

Parameters:
CLK_FREQ, 50_000_000, system clock cycles per second (prescaler terminal count + 1); must be >= 2
HOUR_MAX_BCD, 8'h23, last valid hour before wrap to 00

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
hold  in  1  1 = freeze prescaler and time counters (setting mode)
set_en  in  1  one-cycle load request
set_time  in  24  requested time: [23:16] HH, [15:8] MM, [7:0] SS, BCD
set_ack  out  1  one-cycle pulse: load accepted
set_err  out  1  one-cycle pulse: load rejected (invalid BCD/range)
time_dout  out  24  current time, BCD, same field layout as set_time
sec_tick  out  1  one-cycle pulse on every seconds increment
min_tick  out  1  one-cycle pulse when seconds wrap 59->00

Behaviour:
- Reset (async, rst_n=0): time_dout=24'h000000, prescaler=0, all pulse outputs 0.
- All outputs registered; no combinational path from inputs to outputs.
- Prescaler: counts 0..CLK_FREQ-1 while hold=0 and no accepted load; holds its value while hold=1.
- Increment cycle: edge where prescaler==CLK_FREQ-1 and hold=0 -> prescaler<=0, time advances by 1 s, and sec_tick=1 in the following cycle aligned with the new time_dout.
- BCD seconds/minutes: ones 9->0 with carry into tens; tens 5 with ones 9 -> field 00 with carry into next field.
- Hours: ones 9->0 with tens carry; at HOUR_MAX_BCD with carry -> 00. Full wrap 23:59:59 -> 00:00:00.
- min_tick=1 in the same cycle as sec_tick when SS transitions 59->00; it also fires on the hour and day wraps.
- Load validation: every nibble <=9, SS tens <=5, MM tens <=5, HH <= HOUR_MAX_BCD.
- set_en=1 with valid set_time -> next cycle: time_dout=set_time, prescaler=0, set_ack=1, sec_tick=0.
- set_en=1 with invalid set_time -> next cycle: set_err=1; time and prescaler unchanged; a counting edge in that cycle proceeds normally.
- Simultaneous valid set_en and prescaler terminal count: the load wins and no increment occurs.
- set_en is honoured regardless of hold; hold does not block a load.
- set_en held high for multiple cycles: each cycle is an independent request, producing one ack or err per cycle.
- rst_n asserted during any activity -> immediate return to reset values; any pending pulses are dropped.

Optional Feature:
ALARM_MATCH_EN
- Defined: adds ports alarm_time in 16 (HH:MM BCD) and alarm_hit out 1.
- alarm_hit is a one-cycle pulse issued with min_tick when the new time_dout[23:8] equals alarm_time.
- A load whose value lands exactly on HH:MM:00 equal to alarm_time also pulses alarm_hit in the set_ack cycle.
- alarm_hit resets to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- CLK_FREQ=4, release reset, hold=0 -> sec_tick every 4th cycle; after 3 ticks time_dout=24'h000003; min_tick stays 0.
- Load 24'h235958 (valid), run 2 ticks -> set_ack next cycle; time_dout 235959 then 000000; min_tick coincides with the 000000 tick.
- Load 24'h126000, then 24'h240000, then 24'h0A0000 -> set_err each time; set_ack never asserts; time_dout unchanged.
- hold=1 for 20 cycles starting at 000005 -> time_dout stays 000005 and no sec_tick; release -> prescaler resumes from its held value.
- set_en with 24'h101010 on the same edge as a terminal count -> time_dout=101010, no sec_tick; next tick after exactly 4 cycles gives 101011.
- ALARM_MATCH_EN, alarm_time=16'h0700, load 065959 -> one tick later time_dout=070000 with min_tick=1 and alarm_hit=1 in the same cycle; pulse lasts exactly one cycle.
